// File: rtl/tex_fetch_arbiter.sv
// Round-robin arbiter sharing one synchronous texture ROM port among NUM_REQ clients.
// Optional TEX_ARB_FIXED_PRIO_EN: client 0 has absolute priority, others round-robin.
module tex_fetch_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_dout,
    output logic [15:0]               grant_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      win_idx;
    logic               win_any;
    logic [NUM_REQ-1:0] id_pipe [MEM_LAT];

    always_comb begin
        int                 idx;
        logic [NUM_REQ-1:0] sh;
        win_any = 1'b0;
        win_idx = '0;
        idx     = 0;
        sh      = '0;
`ifdef TEX_ARB_FIXED_PRIO_EN
        // rr_ptr only walks 1..NUM_REQ-1; client 0 bypasses the rotation
        if (req_valid[0]) begin
            win_any = 1'b1;
        end else begin
            for (int k = 1; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) - 1 + k) % (NUM_REQ - 1) + 1;
                sh  = req_valid >> idx;
                if (!win_any && sh[0]) begin
                    win_any = 1'b1;
                    win_idx = PW'(idx);
                end
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            sh  = req_valid >> idx;
            if (!win_any && sh[0]) begin
                win_any = 1'b1;
                win_idx = PW'(idx);
            end
        end
`endif
        if (rst) begin
            win_any = 1'b0;
            win_idx = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        mem_addr  = '0;
        if (win_any) begin
            req_ready = NUM_REQ'(1) << win_idx;
            mem_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
        end
    end

    assign mem_en = win_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= PW'(NUM_REQ - 1);
            grant_cnt <= '0;
        end else if (win_any) begin
            grant_cnt <= grant_cnt + 16'd1;
`ifdef TEX_ARB_FIXED_PRIO_EN
            if (win_idx != '0)
                rr_ptr <= win_idx;
`else
            rr_ptr <= win_idx;
`endif
        end
    end

    // One-hot owner tags travel alongside the ROM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < MEM_LAT; s++)
                id_pipe[s] <= '0;
        end else begin
            id_pipe[0] <= req_ready;
            for (int s = 1; s < MEM_LAT; s++)
                id_pipe[s] <= id_pipe[s-1];
        end
    end

    always_comb begin
        rsp_valid = rst ? '0 : id_pipe[MEM_LAT-1];
        rsp_data  = (|rsp_valid) ? mem_dout : '0;
    end

endmodule

// File: tb/tb_tex_fetch_arbiter.sv
// Directed bench: instance A (2 clients, latency 1), instance B (3 clients, latency 3).
module tb_tex_fetch_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        rst_a;
    logic [1:0]  vld_a, rdy_a, rv_a;
    logic [27:0] addr_a;
    logic [11:0] rd_a, dout_a;
    logic        en_a;
    logic [13:0] ma_a;
    logic [15:0] cnt_a;

    logic        rst_b;
    logic [2:0]  vld_b, rdy_b, rv_b;
    logic [41:0] addr_b;
    logic [11:0] rd_b, dout_b, d1_b, d2_b;
    logic        en_b;
    logic [13:0] ma_b;
    logic [15:0] cnt_b;

    tex_fetch_arbiter #(.NUM_REQ(2), .ADDR_W(14), .DATA_W(12), .MEM_LAT(1)) u_a (
        .clk(clk), .rst(rst_a), .req_valid(vld_a), .req_addr(addr_a),
        .req_ready(rdy_a), .rsp_valid(rv_a), .rsp_data(rd_a), .mem_en(en_a),
        .mem_addr(ma_a), .mem_dout(dout_a), .grant_cnt(cnt_a)
    );

    tex_fetch_arbiter #(.NUM_REQ(3), .ADDR_W(14), .DATA_W(12), .MEM_LAT(3)) u_b (
        .clk(clk), .rst(rst_b), .req_valid(vld_b), .req_addr(addr_b),
        .req_ready(rdy_b), .rsp_valid(rv_b), .rsp_data(rd_b), .mem_en(en_b),
        .mem_addr(ma_b), .mem_dout(dout_b), .grant_cnt(cnt_b)
    );

    function automatic logic [11:0] rom(input logic [13:0] a);
        return a[11:0] ^ 12'hA5A ^ {a[13:12], 10'd0};
    endfunction

    // ROM models: latency 1 for A, latency 3 for B
    always @(posedge clk) begin
        dout_a <= rom(ma_a);
        d1_b   <= rom(ma_b);
        d2_b   <= d1_b;
        dout_b <= d2_b;
    end

    function automatic logic [13:0] b_addr(input logic [2:0] oh);
        case (oh)
            3'b001:  return 14'h100;
            3'b010:  return 14'h200;
            default: return 14'h300;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    logic [2:0] eg [10];
    logic [1:0] ea, pa;

    initial begin
`ifdef TEX_ARB_FIXED_PRIO_EN
        eg = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
               3'b010, 3'b100, 3'b010, 3'b100};
`else
        eg = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
               3'b010, 3'b100, 3'b010, 3'b100};
`endif
        rst_a = 1'b1; vld_a = 2'b11; addr_a = '0;
        rst_b = 1'b1; vld_b = 3'b000; addr_b = '0;
        mid; mid;
        check("rst_ready",  32'(rdy_a), 32'h0);
        check("rst_rspv",   32'(rv_a),  32'h0);
        check("rst_rspd",   32'(rd_a),  32'h0);
        check("rst_memen",  32'(en_a),  32'h0);
        check("rst_cnt",    32'(cnt_a), 32'h0);

        // single read, latency 1
        nxt; rst_a = 1'b0; vld_a = 2'b01; addr_a = {14'h0, 14'h0123};
        mid;
        check("t1_ready", 32'(rdy_a), 32'h1);
        check("t1_memen", 32'(en_a),  32'h1);
        check("t1_maddr", 32'(ma_a),  32'h123);
        nxt; vld_a = 2'b00;
        mid;
        check("t1_rspv",  32'(rv_a),  32'h1);
        check("t1_rspd",  32'(rd_a),  32'(rom(14'h0123)));
        check("t1_idle_en", 32'(en_a), 32'h0);
        check("t1_idle_ma", 32'(ma_a), 32'h0);
        check("t1_cnt",   32'(cnt_a), 32'h1);

        // both valid, alternating grants after reset
        nxt; rst_a = 1'b1;
        nxt; rst_a = 1'b0; vld_a = 2'b11; addr_a = {14'h020, 14'h010};
        pa = 2'b00;
        for (int c = 0; c < 8; c++) begin
            mid;
            ea = (c % 2 == 0) ? 2'b01 : 2'b10;
            check("t2_ready", 32'(rdy_a), 32'(ea));
            check("t2_maddr", 32'(ma_a), (c % 2 == 0) ? 32'h010 : 32'h020);
            if (c > 0) begin
                check("t2_rspv", 32'(rv_a), 32'(pa));
                check("t2_rspd", 32'(rd_a),
                      32'(rom(pa == 2'b01 ? 14'h010 : 14'h020)));
            end
            pa = ea;
            nxt;
        end
        vld_a = 2'b00;
        mid;
        check("t2_last_rspv", 32'(rv_a),  32'h2);
        check("t2_last_rspd", 32'(rd_a),  32'(rom(14'h020)));
        check("t2_cnt",       32'(cnt_a), 32'd8);

        // lone valid client wins immediately
        nxt; vld_a = 2'b10;
        mid;
        check("single_ready", 32'(rdy_a), 32'h2);

        // 16-bit grant counter wrap
        nxt; vld_a = 2'b00; rst_a = 1'b1;
        nxt; rst_a = 1'b0; vld_a = 2'b01; addr_a = {14'h0, 14'h0005};
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_ffff", 32'(cnt_a), 32'hFFFF);
        mid;
        check("wrap_en", 32'(en_a), 32'h1);
        nxt;
        check("wrap_zero", 32'(cnt_a), 32'h0);
        vld_a = 2'b00;
        mid;
        check("wrap_idle_en", 32'(en_a), 32'h0);
        check("wrap_idle_ma", 32'(ma_a), 32'h0);
        nxt; mid;
        check("wrap_hold", 32'(cnt_a), 32'h0);

        // 3 clients, latency 3
        nxt; rst_b = 1'b0; vld_b = 3'b111;
        addr_b = {14'h300, 14'h200, 14'h100};
        for (int c = 0; c < 13; c++) begin
            if (c == 6)  vld_b = 3'b110;
            if (c == 10) vld_b = 3'b000;
            mid;
            check("t3_ready", 32'(rdy_b), (c < 10) ? 32'(eg[c]) : 32'h0);
            if (c >= 3) begin
                check("t3_rspv", 32'(rv_b), 32'(eg[c-3]));
                check("t3_rspd", 32'(rd_b), 32'(rom(b_addr(eg[c-3]))));
            end else begin
                check("t3_rspv0", 32'(rv_b), 32'h0);
            end
            nxt;
        end
        check("t3_cnt", 32'(cnt_b), 32'd10);

        // reset while a read is in flight
        vld_b = 3'b001; addr_b = {14'h300, 14'h200, 14'h055};
        mid;
        check("t4_accept", 32'(rdy_b), 32'h1);
        nxt; rst_b = 1'b1; vld_b = 3'b111;
        mid;
        check("t4_rst_ready", 32'(rdy_b), 32'h0);
        check("t4_rst_rspv",  32'(rv_b),  32'h0);
        nxt; rst_b = 1'b0;
        mid;
        check("t4_first",   32'(rdy_b), 32'h1);
        check("t4_rspv_a",  32'(rv_b),  32'h0);
        check("t4_cnt",     32'(cnt_b), 32'h0);
        nxt; vld_b = 3'b000;
        mid;
        check("t4_rspv_b",  32'(rv_b),  32'h0);
        nxt; mid;
        check("t4_rspv_c",  32'(rv_b),  32'h0);
        nxt; mid;
        check("t4_rspv_d",  32'(rv_b),  32'h1);
        check("t4_rspd",    32'(rd_b),  32'(rom(14'h055)));
        check("t4_cnt_end", 32'(cnt_b), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
